// File: rtl/hamming_dsss_tx_pkg.sv
// Shared types and helpers for the Hamming(7,4) + DSSS transmit coder.
package hdsss_pkg;

  typedef enum logic [1:0] {
    IDLE,
    HEAD,
    FSYNC,
    DATA
  } state_t;

  localparam logic [1:0] SYM_IDLE = 2'b10;
  localparam logic [1:0] SYM_ONE  = 2'b01;
  localparam logic [1:0] SYM_ZERO = 2'b11;

  // Bit 6 is sent first: {p1, p2, d0, p3, d1, d2, d3}.
  function automatic logic [6:0] hamming_encode(input logic [3:0] d);
    logic p1, p2, p3;
    p1 = d[0] ^ d[1] ^ d[3];
    p2 = d[0] ^ d[2] ^ d[3];
    p3 = d[1] ^ d[2] ^ d[3];
    return {p1, p2, d[0], p3, d[1], d[2], d[3]};
  endfunction

endpackage

// File: rtl/hamming_dsss_tx_mseq_gen.sv
// Fibonacci m-sequence generator with synchronous reload; shared with the despreader.
module mseq_gen #(
  parameter int unsigned        LEN  = 5,
  parameter logic [LEN-1:0]     TAPS = LEN'(5'b10100),
  parameter logic [LEN-1:0]     SEED = LEN'(5'b00001)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic adv,
  output logic chip
);

  logic [LEN-1:0] state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= SEED;
    end else if (load) begin
      state <= SEED;
    end else if (adv) begin
      state <= {state[LEN-2:0], ^(state & TAPS)};
    end
  end

  assign chip = state[LEN-1];

endmodule

// File: rtl/hamming_dsss_tx.sv
// Transmit coder: head sync, then repeating frame sync + Hamming(7,4) codewords, each bit spread by an m-sequence.
module hamming_dsss_tx
  import hdsss_pkg::*;
#(
  parameter int unsigned             LFSR_LEN      = 5,
  parameter logic [LFSR_LEN-1:0]     LFSR_TAPS     = LFSR_LEN'(5'b10100),
  parameter logic [LFSR_LEN-1:0]     LFSR_SEED     = LFSR_LEN'(5'b00001),
  parameter int unsigned             HEAD_ONES     = 10,
  parameter int unsigned             SYNC_LEN      = 7,
  parameter int unsigned             FRAME_NIBBLES = 32
) (
  input  logic       clk31,
  input  logic       rst_n,
  input  logic       send_ena,
  input  logic [3:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [1:0] out_data,
  output logic       frame_start,
  output logic       underrun
);

  localparam int unsigned CHIPS    = (1 << LFSR_LEN) - 1;
  localparam int unsigned SPAN_HS  = (HEAD_ONES + 1 > SYNC_LEN) ? HEAD_ONES + 1 : SYNC_LEN;
  localparam int unsigned BIT_SPAN = (SPAN_HS > 7) ? SPAN_HS : 7;
  localparam int unsigned BW       = $clog2(BIT_SPAN);
  localparam int unsigned CWW      = (FRAME_NIBBLES > 1) ? $clog2(FRAME_NIBBLES) : 1;

  localparam logic [LFSR_LEN-1:0] CHIP_LAST   = LFSR_LEN'(CHIPS - 1);
  localparam logic [BW-1:0]       HEAD_ONES_B = BW'(HEAD_ONES);
  localparam logic [BW-1:0]       SYNC_LAST   = BW'(SYNC_LEN - 1);
  localparam logic [BW-1:0]       CW_BIT_LAST = BW'(6);
  localparam logic [CWW-1:0]      CW_LAST     = CWW'(FRAME_NIBBLES - 1);

  state_t              state, st_nxt;
  logic [LFSR_LEN-1:0] chip_cnt;
  logic [BW-1:0]       bit_cnt;
  logic [CWW-1:0]      cw_cnt;
  logic                buf_full, buf_nxt;
  logic [3:0]          buf_data;
  logic [6:0]          cw_reg;
  logic [6:0]          cw_word;
  logic                chip, tx, last_chip, cw_start, accept, cur_bit;
  logic                lfsr_load, lfsr_adv;

  assign tx        = send_ena && (state != IDLE);
  assign last_chip = (chip_cnt == CHIP_LAST);
  assign cw_start  = (state == DATA) && (chip_cnt == '0) && (bit_cnt == '0);
  assign accept    = send_ena && in_valid && in_ready;
  assign cw_word   = hamming_encode(buf_full ? buf_data : 4'b0000);
  assign lfsr_load = !tx || last_chip;
  assign lfsr_adv  = tx && !last_chip;

  mseq_gen #(
    .LEN  (LFSR_LEN),
    .TAPS (LFSR_TAPS),
    .SEED (LFSR_SEED)
  ) u_mseq (
    .clk   (clk31),
    .rst_n (rst_n),
    .load  (lfsr_load),
    .adv   (lfsr_adv),
    .chip  (chip)
  );

  always_comb begin
    st_nxt = state;
    if (!send_ena) begin
      st_nxt = IDLE;
    end else begin
      case (state)
        IDLE:  st_nxt = HEAD;
        HEAD:  if (last_chip && bit_cnt == HEAD_ONES_B) st_nxt = FSYNC;
        FSYNC: if (last_chip && bit_cnt == SYNC_LAST) st_nxt = DATA;
        DATA:  if (last_chip && bit_cnt == CW_BIT_LAST && cw_cnt == CW_LAST) st_nxt = FSYNC;
        default: st_nxt = IDLE;
      endcase
    end

    // An empty buffer at a codeword start can still be loaded in that same cycle.
    buf_nxt = buf_full;
    if (cw_start) buf_nxt = 1'b0;
    if (accept)   buf_nxt = 1'b1;
    if (!send_ena) buf_nxt = 1'b0;

    cur_bit = 1'b0;
    case (state)
      HEAD:    cur_bit = (bit_cnt < HEAD_ONES_B);
      DATA:    cur_bit = cw_start ? cw_word[6] : cw_reg[3'd6 - bit_cnt[2:0]];
      default: cur_bit = 1'b0;
    endcase
  end

  always_ff @(posedge clk31 or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      chip_cnt    <= '0;
      bit_cnt     <= '0;
      cw_cnt      <= '0;
      buf_full    <= 1'b0;
      buf_data    <= '0;
      cw_reg      <= '0;
      in_ready    <= 1'b0;
      out_data    <= SYM_IDLE;
      frame_start <= 1'b0;
      underrun    <= 1'b0;
    end else begin
      state       <= st_nxt;
      buf_full    <= buf_nxt;
      in_ready    <= send_ena && (st_nxt == FSYNC || st_nxt == DATA) && !buf_nxt;
      frame_start <= tx && (state == FSYNC) && (chip_cnt == '0) && (bit_cnt == '0);
      underrun    <= tx && cw_start && !buf_full;
      out_data    <= tx ? ((cur_bit ^ chip) ? SYM_ONE : SYM_ZERO) : SYM_IDLE;

      if (accept) buf_data <= in_data;
      if (cw_start) cw_reg <= cw_word;

      if (!tx) begin
        chip_cnt <= '0;
        bit_cnt  <= '0;
        cw_cnt   <= '0;
      end else if (!last_chip) begin
        chip_cnt <= chip_cnt + 1'b1;
      end else begin
        chip_cnt <= '0;
        if (st_nxt != state) begin
          bit_cnt <= '0;
          cw_cnt  <= '0;
        end else if (state == DATA && bit_cnt == CW_BIT_LAST) begin
          bit_cnt <= '0;
          cw_cnt  <= cw_cnt + 1'b1;
        end else begin
          bit_cnt <= bit_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_hamming_dsss_tx.sv
// Directed bench for hamming_dsss_tx: default instance plus a small-parameter instance.
module tb_hamming_dsss_tx;

  logic       clk31 = 1'b0;
  logic       rst_n, send_ena, in_valid, in_ready, frame_start, underrun;
  logic [3:0] in_data;
  logic [1:0] out_data;
  logic       send_ena1, in_valid1, in_ready1, frame_start1, underrun1;
  logic [3:0] in_data1;
  logic [1:0] out_data1;

  int checks = 0;
  int errors = 0;

  logic [1:0] head5[5]  = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b11};
  logic [1:0] small7[7] = '{2'b01, 2'b01, 2'b11, 2'b01, 2'b11, 2'b11, 2'b11};

  always #5 clk31 = ~clk31;

  hamming_dsss_tx u_dut (
    .clk31       (clk31),
    .rst_n       (rst_n),
    .send_ena    (send_ena),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .out_data    (out_data),
    .frame_start (frame_start),
    .underrun    (underrun)
  );

  hamming_dsss_tx #(
    .LFSR_LEN      (3),
    .LFSR_TAPS     (3'b110),
    .LFSR_SEED     (3'b001),
    .HEAD_ONES     (4),
    .SYNC_LEN      (7),
    .FRAME_NIBBLES (2)
  ) u_small (
    .clk31       (clk31),
    .rst_n       (rst_n),
    .send_ena    (send_ena1),
    .in_data     (in_data1),
    .in_valid    (in_valid1),
    .in_ready    (in_ready1),
    .out_data    (out_data1),
    .frame_start (frame_start1),
    .underrun    (underrun1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk31);
    #1;
  endtask

  function automatic int mchip(input int len, input int taps, input int seed, input int k);
    int st;
    int fb;
    st = seed;
    for (int i = 0; i < k; i++) begin
      fb = $countones(st & taps) & 1;
      st = ((st << 1) | fb) & ((1 << len) - 1);
    end
    return (st >> (len - 1)) & 1;
  endfunction

  function automatic logic [1:0] sym(input int b, input int c);
    return ((b ^ c) & 1) ? 2'b01 : 2'b11;
  endfunction

  // Hand-computed codewords, transmit order p1 p2 d0 p3 d1 d2 d3 (MSB first).
  function automatic logic [6:0] cw_tab(input logic [3:0] n);
    case (n)
      4'h0: return 7'b0000000;  4'h1: return 7'b1110000;
      4'h2: return 7'b1001100;  4'h3: return 7'b0111100;
      4'h4: return 7'b0101010;  4'h5: return 7'b1011010;
      4'h6: return 7'b1100110;  4'h7: return 7'b0010110;
      4'h8: return 7'b1101001;  4'h9: return 7'b0011001;
      4'hA: return 7'b0100101;  4'hB: return 7'b1010101;
      4'hC: return 7'b1000011;  4'hD: return 7'b0110011;
      4'hE: return 7'b0001111;  default: return 7'b1111111;
    endcase
  endfunction

  function automatic logic [3:0] nib(input int i);
    return (i == 0) ? 4'hB : 4'((i * 5 + 3) % 16);
  endfunction

  initial begin
    int sent;
    int d, cw, b;
    logic acc;
    logic [6:0] w;

    rst_n = 1'b0; send_ena = 1'b0; in_valid = 1'b0; in_data = 4'h0;
    send_ena1 = 1'b0; in_valid1 = 1'b0; in_data1 = 4'h0;
    tick(2);
    chk("rst_out_data", 32'(out_data), 32'(2'b10));
    chk("rst_in_ready", 32'(in_ready), 32'(1'b0));
    chk("rst_frame_start", 32'(frame_start), 32'(1'b0));
    chk("rst_underrun", 32'(underrun), 32'(1'b0));

    rst_n = 1'b1;
    tick(1);
    send_ena = 1'b1;
    tick(1);
    chk("idle_before_head", 32'(out_data), 32'(2'b10));
    tick(1);

    // Head: 10 ones + one zero, 31 chips each.
    for (int t = 0; t < 341; t++) begin
      chk("head_chip", 32'(out_data), 32'(sym((t / 31) < 10 ? 1 : 0, mchip(5, 'b10100, 1, t % 31))));
      chk("head_no_fs", 32'(frame_start), 32'(1'b0));
      if (t < 5) chk("head_first5", 32'(out_data), 32'(head5[t]));
      if (t < 340) chk("head_not_ready", 32'(in_ready), 32'(1'b0));
      tick(1);
    end

    chk("fsync1_frame_start", 32'(frame_start), 32'(1'b1));
    chk("fsync1_ready", 32'(in_ready), 32'(1'b1));

    // Frame 1: prefill during FSYNC, then 32 nibbles streamed with in_valid held.
    sent = 0;
    in_valid = 1'b1;
    in_data = nib(0);
    for (int t = 341; t < 7502; t++) begin
      if (t < 558) begin
        b = 0;
      end else begin
        d  = t - 558;
        cw = d / 217;
        w  = cw_tab(nib(cw));
        b  = w[6 - (d % 217) / 31];
      end
      chk("frame1_chip", 32'(out_data), 32'(sym(b, mchip(5, 'b10100, 1, t % 31))));
      chk("frame1_no_underrun", 32'(underrun), 32'(1'b0));
      chk("frame1_fs", 32'(frame_start), 32'(t == 341));
      acc = in_valid && in_ready;
      tick(1);
      if (acc) begin
        chk("accept_ready_drop", 32'(in_ready), 32'(1'b0));
        sent++;
        if (sent >= 32) in_valid = 1'b0;
        else in_data = nib(sent);
      end
    end
    chk("nibbles_accepted", 32'(sent), 32'd32);
    chk("fsync2_frame_start", 32'(frame_start), 32'(1'b1));
    chk("fsync2_ready", 32'(in_ready), 32'(1'b1));

    for (int t = 7502; t < 7719; t++) begin
      chk("fsync2_chip", 32'(out_data), 32'(sym(0, mchip(5, 'b10100, 1, t % 31))));
      chk("fsync2_fs", 32'(frame_start), 32'(t == 7502));
      tick(1);
    end

    // Nothing buffered at codeword 0 of frame 2: fill codeword and underrun pulse.
    chk("underrun_pulse", 32'(underrun), 32'(1'b1));
    chk("underrun_chip0", 32'(out_data), 32'(2'b11));
    chk("underrun_ready", 32'(in_ready), 32'(1'b1));
    in_valid = 1'b1;
    in_data = 4'h6;
    tick(1);
    chk("late_accept", 32'(in_ready), 32'(1'b0));
    chk("underrun_one_cycle", 32'(underrun), 32'(1'b0));
    in_valid = 1'b0;
    for (int t = 7720; t < 8000; t++) begin
      d = t - 7719;
      w = (d < 217) ? 7'b0000000 : cw_tab(4'h6);
      b = w[6 - (d % 217) / 31];
      chk("frame2_chip", 32'(out_data), 32'(sym(b, mchip(5, 'b10100, 1, t % 31))));
      chk("frame2_no_underrun", 32'(underrun), 32'(1'b0));
      tick(1);
    end

    // Drop enable mid-DATA, then restart from head.
    send_ena = 1'b0;
    tick(1);
    chk("disable_idle", 32'(out_data), 32'(2'b10));
    chk("disable_ready", 32'(in_ready), 32'(1'b0));
    chk("disable_fs", 32'(frame_start), 32'(1'b0));
    tick(3);
    chk("disable_hold", 32'(out_data), 32'(2'b10));
    send_ena = 1'b1;
    tick(1);
    chk("reenable_idle", 32'(out_data), 32'(2'b10));
    tick(1);
    for (int t = 0; t < 31; t++) begin
      chk("restart_head_chip", 32'(out_data), 32'(sym(1, mchip(5, 'b10100, 1, t))));
      if (t < 5) chk("restart_first5", 32'(out_data), 32'(head5[t]));
      tick(1);
    end

    // Small instance: 7 chips/bit, 5-bit head, 147-cycle frame, all fill codewords.
    send_ena1 = 1'b1;
    tick(1);
    chk("small_idle", 32'(out_data1), 32'(2'b10));
    tick(1);
    for (int t = 0; t < 200; t++) begin
      chk("small_chip", 32'(out_data1), 32'(sym(t < 28 ? 1 : 0, mchip(3, 'b110, 1, t % 7))));
      chk("small_fs", 32'(frame_start1), 32'(t == 35 || t == 182));
      chk("small_underrun", 32'(underrun1), 32'(t == 84 || t == 133));
      if (t < 7) chk("small_first7", 32'(out_data1), 32'(small7[t]));
      tick(1);
    end

    // Async reset in the middle of transmission.
    #2;
    rst_n = 1'b0;
    #2;
    chk("async_rst_small", 32'(out_data1), 32'(2'b10));
    chk("async_rst_main", 32'(out_data), 32'(2'b10));
    chk("async_rst_ready", 32'(in_ready1), 32'(1'b0));
    rst_n = 1'b1;
    tick(1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
